// File: rtl/stdio_arbiter.sv
// Round-robin arbiter sharing one stdio sink between N producers, holding each grant for up to BURST words.
// Optional build macro STDIO_ARB_PRIO_EN gives requester 0 absolute priority in IDLE.
module stdio_arbiter #(
  parameter int N     = 2,
  parameter int BURST = 4,
  localparam int GW   = (N > 1) ? $clog2(N) : 1,
  localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_val_i,
  input  logic [16*N-1:0] req_data_i,
  output logic [N-1:0]    req_rdy_o,
  output logic            stdout_val_o,
  input  logic            stdout_rdy_i,
  output logic [15:0]     stdout_data_o,
  output logic [GW-1:0]   gnt_o,
  output logic            busy_o
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e        state_q;
  logic [GW-1:0] rr_ptr_q, gnt_q, gnt_d, rr_ptr_d;
  logic [CW-1:0] cnt_q;
  logic          pick_vld, cur_val;
  int            best_off, off;

  // Candidate with the smallest distance from rr_ptr wins; indices >= N never exist here.
  always_comb begin
    pick_vld = 1'b0;
    gnt_d    = rr_ptr_q;
    best_off = N;
    off      = 0;
    for (int k = 0; k < N; k++) begin
      off = (k + N - int'(rr_ptr_q)) % N;
      if (req_val_i[k] && off < best_off) begin
        best_off = off;
        gnt_d    = GW'(k);
        pick_vld = 1'b1;
      end
    end
`ifdef STDIO_ARB_PRIO_EN
    if (req_val_i[0]) begin
      pick_vld = 1'b1;
      gnt_d    = '0;
    end
`endif
  end

  always_comb begin
    rr_ptr_d = (gnt_q == GW'(N-1)) ? '0 : gnt_q + 1'b1;
`ifdef STDIO_ARB_PRIO_EN
    // Requester-0 grants leave the others' rotation untouched.
    if (gnt_q == '0) rr_ptr_d = rr_ptr_q;
`endif
  end

  always_comb begin
    cur_val       = 1'b0;
    stdout_data_o = '0;
    req_rdy_o     = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q == GW'(k)) begin
        cur_val       = req_val_i[k];
        stdout_data_o = req_data_i[16*k +: 16];
        req_rdy_o[k]  = (state_q == LOCK) && stdout_rdy_i;
      end
    end
  end

  assign stdout_val_o = (state_q == LOCK) && cur_val;
  assign busy_o       = (state_q == LOCK);
  assign gnt_o        = gnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_q   <= gnt_d;
            cnt_q   <= '0;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (!cur_val) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end else if (stdout_rdy_i) begin
            if (cnt_q == CW'(BURST-1)) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stdio_arbiter.sv
// Directed bench for stdio_arbiter: an N=2 instance and an N=3 instance, both BURST=4.
module tb_stdio_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;

  logic [1:0]  v2, r2o;
  logic        rdy2, val2o, b2;
  logic [31:0] d2;
  logic [15:0] do2;
  logic [0:0]  g2;

  logic [2:0]  v3, r3o;
  logic        rdy3, val3o, b3;
  logic [47:0] d3;
  logic [15:0] do3;
  logic [1:0]  g3;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ia, ib;
  logic [15:0] ba, bb;

  int ev1 [12] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
  int ed1 [12] = '{0, 'hA000, 'hA001, 'hA002, 'hA003, 0,
                   'hB000, 'hB001, 'hB002, 'hB003, 0, 'hA004};
  int eg1 [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int pat3 [9] = '{7, 7, 7, 7, 6, 6, 6, 6, 7};
`ifdef STDIO_ARB_PRIO_EN
  int eg3 [9]  = '{0, 0, 0, 0, 1, 2, 1, 2, 0};
`else
  int eg3 [9]  = '{0, 1, 2, 0, 1, 2, 1, 2, 0};
`endif

  always #5 clk = ~clk;

  stdio_arbiter #(.N(2), .BURST(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .req_val_i(v2), .req_data_i(d2), .req_rdy_o(r2o),
    .stdout_val_o(val2o), .stdout_rdy_i(rdy2), .stdout_data_o(do2), .gnt_o(g2), .busy_o(b2));

  stdio_arbiter #(.N(3), .BURST(4)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .req_val_i(v3), .req_data_i(d3), .req_rdy_o(r3o),
    .stdout_val_o(val3o), .stdout_rdy_i(rdy3), .stdout_data_o(do3), .gnt_o(g3), .busy_o(b3));

  task automatic fail(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Producer model for u2: each requester advances its word on its own handshake.
  task automatic cyc;
    if (r2o[0] && v2[0]) ia++;
    if (r2o[1] && v2[1]) ib++;
    @(posedge clk);
    #1;
    d2 = {bb + 16'(ib), ba + 16'(ia)};
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v2 = '0; rdy2 = 1'b0; d2 = '0;
    v3 = '0; rdy3 = 1'b0; d3 = '0;
    ia = 0; ib = 0; ba = 16'hA000; bb = 16'hB000;
    repeat (2) @(posedge clk);
    #2;
    n_chk++; if (b2 !== 1'b0) fail("rst_busy", b2, 1'b0);
    n_chk++; if (val2o !== 1'b0) fail("rst_val", val2o, 1'b0);
    n_chk++; if (r2o !== 2'b00) fail("rst_rdy", r2o, 2'b00);
    n_chk++; if (g2 !== 1'b0) fail("rst_gnt", g2, 1'b0);
    n_chk++; if (do2 !== 16'h0000) fail("rst_data", do2, 16'h0000);

    // Both requesting continuously: A-burst, idle, B-burst, idle, A again.
    rst_n = 1'b1; v2 = 2'b11; rdy2 = 1'b1; d2 = {bb, ba};
    #1;
    for (int c = 0; c < 12; c++) begin
      n_chk++; if (val2o !== (ev1[c] != 0)) fail("rr_val", val2o, ev1[c] != 0);
      if (ev1[c] != 0) begin
        n_chk++; if (do2 !== 16'(ed1[c])) fail("rr_data", do2, 16'(ed1[c]));
        n_chk++; if (g2 !== 1'(eg1[c])) fail("rr_gnt", g2, 1'(eg1[c]));
      end else begin
        n_chk++; if (b2 !== 1'b0) fail("rr_idle_busy", b2, 1'b0);
      end
      cyc();
    end

    // Asynchronous reset in the middle of word 2 of the second A burst.
    n_chk++; if (do2 !== 16'hA005) fail("pre_rst_data", do2, 16'hA005);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (val2o !== 1'b0) fail("arst_val", val2o, 1'b0);
    n_chk++; if (r2o !== 2'b00) fail("arst_rdy", r2o, 2'b00);
    n_chk++; if (b2 !== 1'b0) fail("arst_busy", b2, 1'b0);
    #1 rst_n = 1'b1;
    cyc();
    n_chk++; if (g2 !== 1'b0) fail("post_rst_gnt", g2, 1'b0);
    n_chk++; if (do2 !== 16'hA005) fail("post_rst_data", do2, 16'hA005);
    n_chk++; if (val2o !== 1'b1) fail("post_rst_val", val2o, 1'b1);
    v2 = 2'b00;
    #1;
    cyc();
    cyc();

    // Requester 1 alone, two words then drops.
    ia = 0; ib = 0; bb = 16'hC000; d2 = {bb, ba};
    v2 = 2'b10;
    #1;
    n_chk++; if (val2o !== 1'b0) fail("r1_idle_val", val2o, 1'b0);
    cyc();
    n_chk++; if (b2 !== 1'b1) fail("r1_busy", b2, 1'b1);
    n_chk++; if (g2 !== 1'b1) fail("r1_gnt", g2, 1'b1);
    n_chk++; if (do2 !== 16'hC000) fail("r1_w0", do2, 16'hC000);
    n_chk++; if (r2o !== 2'b10) fail("r1_rdy", r2o, 2'b10);
    cyc();
    n_chk++; if (do2 !== 16'hC001) fail("r1_w1", do2, 16'hC001);
    cyc();
    v2 = 2'b00;
    #1;
    n_chk++; if (val2o !== 1'b0) fail("r1_drop_val", val2o, 1'b0);
    n_chk++; if (b2 !== 1'b1) fail("r1_drop_busy", b2, 1'b1);
    cyc();
    n_chk++; if (b2 !== 1'b0) fail("r1_after_busy", b2, 1'b0);
    n_chk++; if (ib !== 2) fail("r1_count", ib, 2);

    // Backpressure on a requester-0 burst; rr_ptr must be back at 0.
    ia = 0; ib = 0; ba = 16'hD000; bb = 16'hE000; d2 = {bb, ba};
    v2 = 2'b11;
    #1;
    cyc();
    n_chk++; if (g2 !== 1'b0) fail("bp_gnt", g2, 1'b0);
    n_chk++; if (do2 !== 16'hD000) fail("bp_w0", do2, 16'hD000);
    cyc();
    n_chk++; if (do2 !== 16'hD001) fail("bp_w1", do2, 16'hD001);
    cyc();
    rdy2 = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      n_chk++; if (do2 !== 16'hD002) fail("bp_stall_data", do2, 16'hD002);
      n_chk++; if (r2o !== 2'b00) fail("bp_stall_rdy", r2o, 2'b00);
      n_chk++; if (b2 !== 1'b1) fail("bp_stall_busy", b2, 1'b1);
      cyc();
    end
    rdy2 = 1'b1;
    #1;
    n_chk++; if (do2 !== 16'hD002) fail("bp_w2", do2, 16'hD002);
    cyc();
    n_chk++; if (do2 !== 16'hD003) fail("bp_w3", do2, 16'hD003);
    n_chk++; if (b2 !== 1'b1) fail("bp_w3_busy", b2, 1'b1);
    cyc();
    n_chk++; if (b2 !== 1'b0) fail("bp_release", b2, 1'b0);
    n_chk++; if (ia !== 4) fail("bp_total", ia, 4);
    cyc();
    n_chk++; if (g2 !== 1'b1) fail("bp_next_gnt", g2, 1'b1);
    v2 = 2'b00;

    // N=3, only requester 2 from rr_ptr=0, then wrap back to 0.
    d3 = {16'hE000, 16'h2000, 16'h1000};
    v3 = 3'b100; rdy3 = 1'b1;
    #1;
    n_chk++; if (b3 !== 1'b0) fail("n3_idle_busy", b3, 1'b0);
    cyc();
    n_chk++; if (b3 !== 1'b1) fail("n3_busy", b3, 1'b1);
    n_chk++; if (g3 !== 2'd2) fail("n3_gnt", g3, 2'd2);
    n_chk++; if (do3 !== 16'hE000) fail("n3_data", do3, 16'hE000);
    n_chk++; if (r3o !== 3'b100) fail("n3_rdy", r3o, 3'b100);
    v3 = 3'b000;
    #1;
    cyc();
    n_chk++; if (b3 !== 1'b0) fail("n3_release", b3, 1'b0);

    // N=3 grant order with everyone requesting, then requester 0 withdrawing.
    for (int g = 0; g < 9; g++) begin
      v3 = 3'(pat3[g]);
      #1;
      cyc();
      n_chk++; if (g3 !== 2'(eg3[g])) fail("n3_order", g3, 2'(eg3[g]));
      repeat (4) cyc();
    end
    v3 = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
